// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle processor main control FSM (Moore outputs, memReady Mealy terms)

module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       instrDone,
  output logic       illegalOp,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       op_undefined;

  // Classify the held opcode; only meaningful while sitting in DECODE
  always_comb begin
    op_undefined = 1'b1;
    case (opCode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_undefined = 1'b0;
      default:                                       op_undefined = 1'b1;
    endcase
  end

  // State and sticky illegal-opcode flag registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state sequencing; the illegal flag never feeds back into sequencing
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:     state_d = memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opCode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDI_EXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = memReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // Datapath controls decoded from the current state (plus memReady in FETCH/MEM_WRITE)
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUop       = 2'b00;
    PCSource    = 2'b00;
    instrDone   = 1'b0;
    case (state_q)
      S_FETCH: begin
        memRead = 1'b1;
        ALUSrcB = 2'b01;
        pcWrite = memReady;
        irWrite = memReady;
      end
      S_DECODE: begin
        ALUSrcB   = 2'b11;
        instrDone = op_undefined;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        memRead = 1'b1;
        iorD    = 1'b1;
      end
      S_MEM_WB: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_MEM_WRITE: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        instrDone = memReady;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
      end
      S_R_WB: begin
        regDst    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_ADDI_WB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        pcWriteCond = 1'b1;
        PCSource    = 2'b01;
        instrDone   = 1'b1;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        PCSource  = 2'b10;
        instrDone = 1'b1;
      end
      default: begin
        pcWrite = 1'b0;
      end
    endcase
  end

  assign illegalOp = illegal_q;
  assign state     = state_q;

endmodule
